// File: rtl/delay_pkg.sv
// Shared sample type, ring addressing helper and defaults for the delay tap reader.
// Optional feature macro used by the top: DELAY_TAP_FILL_CHECK_EN.
`ifndef DELAY_PKG_SV
`define DELAY_PKG_SV

// Sample type of parameterised width; a package typedef cannot carry a parameter.
`define DELAY_SAMPLE_T(w) logic [(w)-1:0]

package delay_pkg;

    localparam int DELAY_DEFAULT_DEPTH = 32;
    localparam int DELAY_DEFAULT_SIZE  = 16;

    // Widest pointer the helper handles; callers zero-extend in and truncate out.
    localparam int RING_AW_MAX = 32;

    typedef logic [RING_AW_MAX-1:0] ring_ptr_t;

    // Slot holding the sample written `lag` writes before the newest one.
    // Low bits of the difference only depend on low bits of the operands,
    // so truncating the result to the real pointer width wraps correctly.
    function automatic ring_ptr_t ring_addr(input ring_ptr_t wr_ptr, input ring_ptr_t lag);
        return wr_ptr - ring_ptr_t'(1) - lag;
    endfunction

endpackage

`endif

// File: rtl/delay_ring_mem.sv
// Ring storage for the delay tap reader: one synchronous write port, one
// asynchronous read port, no reset on the array. Macro: DELAY_TAP_FILL_CHECK_EN (unused here).
module delay_ring_mem
    import delay_pkg::*;
#(
    parameter  int size  = DELAY_DEFAULT_SIZE,
    parameter  int depth = DELAY_DEFAULT_DEPTH,
    localparam int LW    = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 we,
    input  logic [LW-1:0]        waddr,
    input  `DELAY_SAMPLE_T(size) wdata,
    input  logic [LW-1:0]        raddr,
    output `DELAY_SAMPLE_T(size) rdata
);

    `DELAY_SAMPLE_T(size) mem [depth];

    always_ff @(posedge clk) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
    end

    // Combinational read returns the pre-edge contents, giving read-before-write.
    assign rdata = mem[raddr];

endmodule

// File: rtl/delay_tap_reader.sv
// Ring-buffered sample history with handshaked random-lag reads (lag 0 = newest sample).
// Macro DELAY_TAP_FILL_CHECK_EN adds out_err and zeroes responses for lags not yet written.
module delay_tap_reader
    import delay_pkg::*;
#(
    parameter  int size  = DELAY_DEFAULT_SIZE,
    parameter  int depth = DELAY_DEFAULT_DEPTH,
    localparam int LW    = $clog2(depth)
) (
    input  logic                 clk,
    input  logic                 rstn,
    input  logic                 in_valid,
    input  `DELAY_SAMPLE_T(size) in,
    input  logic                 rd_valid,
    input  logic [LW-1:0]        rd_lag,
    output logic                 rd_ready,
    output logic                 out_valid,
    input  logic                 out_ready,
    output `DELAY_SAMPLE_T(size) out
`ifdef DELAY_TAP_FILL_CHECK_EN
    ,
    output logic                 out_err
`endif
);

    localparam logic [LW:0] FILL_MAX = (LW+1)'(depth);

    logic [LW-1:0]        wr_ptr;
    logic [LW:0]          fill;
    logic [LW-1:0]        rd_addr;
    `DELAY_SAMPLE_T(size) rd_data;
    logic                 rd_acc;
    logic                 lag_unfilled;

    // Single output register: a new request may enter whenever the slot drains this cycle.
    assign rd_ready = !out_valid || out_ready;
    assign rd_acc   = rd_valid && rd_ready;
    assign rd_addr  = LW'(ring_addr(ring_ptr_t'(wr_ptr), ring_ptr_t'(rd_lag)));

    delay_ring_mem #(
        .size  (size),
        .depth (depth)
    ) u_mem (
        .clk   (clk),
        .we    (in_valid),
        .waddr (wr_ptr),
        .wdata (in),
        .raddr (rd_addr),
        .rdata (rd_data)
    );

    // Writes never stall; fill saturates once every slot holds a real sample.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            wr_ptr <= '0;
            fill   <= '0;
        end else if (in_valid) begin
            wr_ptr <= wr_ptr + LW'(1);
            if (fill != FILL_MAX) begin
                fill <= fill + (LW+1)'(1);
            end
        end
    end

`ifdef DELAY_TAP_FILL_CHECK_EN
    assign lag_unfilled = ({1'b0, rd_lag} >= fill);

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_err <= 1'b0;
        end else if (rd_acc) begin
            out_err <= lag_unfilled;
        end
    end
`else
    // Fill is still tracked without the checker; fold it into a deliberately unused net.
    logic fill_unused;
    assign fill_unused  = ^fill;
    assign lag_unfilled = 1'b0;
`endif

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            out_valid <= 1'b0;
            out       <= '0;
        end else if (rd_acc) begin
            out_valid <= 1'b1;
            out       <= lag_unfilled ? '0 : rd_data;
        end else if (out_ready) begin
            out_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_delay_tap_reader.sv
// Scoreboard bench for delay_tap_reader: directed cases then a randomized run.
// Build with DELAY_TAP_FILL_CHECK_EN defined to also exercise out_err.
module tb_delay_tap_reader;

    localparam int SIZE  = 16;
    localparam int DEPTH = 32;
    localparam int LW    = 5;

    typedef struct {
        logic [SIZE-1:0] d;
        logic            e;
    } exp_t;

    logic            clk = 1'b0;
    logic            rstn = 1'b0;
    logic            in_valid = 1'b0;
    logic [SIZE-1:0] in_d = '0;
    logic            rd_valid = 1'b0;
    logic [LW-1:0]   rd_lag = '0;
    logic            rd_ready;
    logic            out_valid;
    logic            out_ready = 1'b0;
    logic [SIZE-1:0] out_d;
`ifdef DELAY_TAP_FILL_CHECK_EN
    logic            out_err_w;
`endif

    exp_t            exp_q[$];
    logic [SIZE-1:0] hist[$];
    exp_t            me;
    int              checks = 0;
    int              errors = 0;
    logic            a;

    delay_tap_reader #(.size(SIZE), .depth(DEPTH)) dut (
        .clk       (clk),
        .rstn      (rstn),
        .in_valid  (in_valid),
        .in        (in_d),
        .rd_valid  (rd_valid),
        .rd_lag    (rd_lag),
        .rd_ready  (rd_ready),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out       (out_d)
`ifdef DELAY_TAP_FILL_CHECK_EN
        ,
        .out_err   (out_err_w)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    // One cycle of stimulus; if the read is accepted its expected response is queued.
    task automatic step(input logic wv, input logic [SIZE-1:0] wd, input logic rv,
                        input logic [LW-1:0] lag, input logic ordy, input logic hand,
                        input logic [SIZE-1:0] hd, input logic he, output logic acc);
        exp_t e;
        in_valid  = wv;
        in_d      = wd;
        rd_valid  = rv;
        rd_lag    = lag;
        out_ready = ordy;
        #1;
        acc = rv && rd_ready;
        if (acc) begin
            if (hand) begin
                e.d = hd;
                e.e = he;
            end else if (int'(lag) < hist.size()) begin
                e.d = hist[lag];
                e.e = 1'b0;
            end else begin
                e.d = '0;
                e.e = 1'b1;
            end
            exp_q.push_back(e);
        end
        if (wv) begin
            hist.push_front(wd);
            if (hist.size() > DEPTH) void'(hist.pop_back());
        end
        @(posedge clk);
        #1;
        if (acc) chk("latency1_valid", out_valid, 1);
    endtask

    task automatic wr(input logic [SIZE-1:0] v);
        logic x;
        step(1'b1, v, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, x);
    endtask

    task automatic rd(input logic [LW-1:0] lag, input logic ordy, input logic [SIZE-1:0] d, input logic e);
        logic x;
        step(1'b0, '0, 1'b1, lag, ordy, 1'b1, d, e, x);
        chk("rd_accept", x, 1);
    endtask

    task automatic idle();
        logic x;
        step(1'b0, '0, 1'b0, '0, 1'b1, 1'b0, '0, 1'b0, x);
    endtask

    task automatic do_reset();
        rstn      = 1'b0;
        in_valid  = 1'b0;
        rd_valid  = 1'b0;
        out_ready = 1'b1;
        #1;
        exp_q.delete();
        hist.delete();
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_out", out_d, 0);
        chk("rst_rd_ready", rd_ready, 1);
`ifdef DELAY_TAP_FILL_CHECK_EN
        chk("rst_out_err", out_err_w, 0);
`endif
    endtask

    // Monitor: every consumed response is matched against the scoreboard.
    always @(negedge clk) begin
        if (rstn && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_rsp: got %0h expected none", out_d);
            end else begin
                me = exp_q.pop_front();
                chk("rsp_data", out_d, me.d);
`ifdef DELAY_TAP_FILL_CHECK_EN
                chk("rsp_err", out_err_w, me.e);
`endif
            end
        end
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic wv, rv, ordy;
        logic [LW-1:0] lag;

        // 1: wrap-around history reads
        do_reset();
        for (int v = 1; v <= 40; v++) wr(SIZE'(v));
        rd(5'd0, 1'b1, 16'd40, 1'b0);
        rd(5'd5, 1'b1, 16'd35, 1'b0);
        rd(5'd31, 1'b1, 16'd9, 1'b0);
        idle();

        // 2: read-before-write in the same cycle
        do_reset();
        for (int v = 1; v <= 6; v++) wr(SIZE'(v));
        step(1'b1, 16'd7, 1'b1, 5'd0, 1'b1, 1'b1, 16'd6, 1'b0, a);
        chk("rbw_accept", a, 1);
        rd(5'd0, 1'b1, 16'd7, 1'b0);
        idle();

        // 3: backpressure holds the response, then back-to-back accepts
        rd(5'd0, 1'b0, 16'd7, 1'b0);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, '0, 1'b1, 5'd3, 1'b0, 1'b0, '0, 1'b0, a);
            chk("stall_no_accept", a, 0);
            chk("stall_rd_ready", rd_ready, 0);
            chk("stall_out", out_d, 16'd7);
            chk("stall_valid", out_valid, 1);
        end
        rd(5'd1, 1'b1, 16'd6, 1'b0);
        rd(5'd2, 1'b1, 16'd5, 1'b0);
        rd(5'd5, 1'b1, 16'd2, 1'b0);
        idle();

        // 4: partially filled ring
        do_reset();
        wr(16'd10);
        wr(16'd11);
        wr(16'd12);
        rd(5'd2, 1'b1, 16'd10, 1'b0);
`ifdef DELAY_TAP_FILL_CHECK_EN
        rd(5'd3, 1'b1, 16'd0, 1'b1);
`endif
        idle();

        // 5: async reset while a response is held
        rd(5'd0, 1'b0, 16'd12, 1'b0);
        #2;
        rstn = 1'b0;
        #1;
        chk("async_rst_valid", out_valid, 0);
        chk("async_rst_out", out_d, 0);
        exp_q.delete();
        hist.delete();
        rd_valid  = 1'b0;
        out_ready = 1'b1;
        @(posedge clk);
        #1;
        rstn = 1'b1;
        chk("post_rst_valid", out_valid, 0);
`ifdef DELAY_TAP_FILL_CHECK_EN
        rd(5'd0, 1'b1, 16'd0, 1'b1);
`endif
        idle();

        // 6: randomized traffic against the history model
        for (int i = 0; i < 10000; i++) begin
            wv   = 1'($urandom_range(0, 1));
            rv   = 1'($urandom_range(0, 1));
            lag  = LW'($urandom_range(0, DEPTH - 1));
            ordy = ($urandom_range(0, 3) != 0);
`ifndef DELAY_TAP_FILL_CHECK_EN
            if (int'(lag) >= hist.size()) rv = 1'b0;
`endif
            step(wv, SIZE'($urandom), rv, lag, ordy, 1'b0, '0, 1'b0, a);
        end
        idle();
        idle();
        chk("queue_drained", exp_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
